// File: rtl/render_pkg.sv
// Shared constants, state encoding and register indices
// for the render pipeline stages.
package render_pkg;

  localparam int DEF_X_W    = 11;
  localparam int DEF_Y_W    = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;

  localparam int DEF_X_MAX = 1079;
  localparam int DEF_Y_MAX = 2159;

  localparam int REG_X     = 0;
  localparam int REG_Y     = 1;
  localparam int REG_W     = 2;
  localparam int REG_H     = 3;
  localparam int REG_COLOR = 4;

  localparam logic [31:0] BLUE = 32'hFF0000FF;
  localparam logic [31:0] RED  = 32'hFFFF0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } src_state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster position counter: y is the fast axis, x the slow one.
// Wraps to (0,0) after (X_MAX,Y_MAX); last flags that position.
module raster_counter #(
  parameter int X_W   = 11,
  parameter int Y_W   = 12,
  parameter int X_MAX = 1079,
  parameter int Y_MAX = 2159
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  if (X_MAX >= (1 << X_W)) begin : g_x_chk
    $error("X_MAX does not fit in X_W");
  end
  if (Y_MAX >= (1 << Y_W)) begin : g_y_chk
    $error("Y_MAX does not fit in Y_W");
  end

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           y_end;
  logic           x_end;

  assign y_end = (y_q == Y_W'(Y_MAX));
  assign x_end = (x_q == X_W'(X_MAX));

  // next position: clear wins, otherwise step when enabled
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (y_end) begin
        y_d = '0;
        x_d = x_end ? '0 : x_q + 1'b1;
      end else begin
        y_d = y_q + 1'b1;
      end
    end
  end

  // position register
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end & y_end;

endmodule

// File: rtl/pixel_stream_source.sv
// Head of the render pipeline: config writes become program
// beats; a start request streams a background-coloured frame.
module pixel_stream_source
  import render_pkg::*;
#(
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int X_MAX  = DEF_X_MAX,
  parameter int Y_MAX  = DEF_Y_MAX,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  input  logic              continuous,
  input  logic [DATA_W-1:0] bg_color,
  output logic              program_out,
  output logic              pixel_valid,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_done,
  output logic              busy
);

  src_state_e state_q, state_d;

  logic              prog_q, prog_d;
  logic              pv_q, pv_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fd_q, fd_d;
  logic              busy_q, busy_d;
  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] bg_q, bg_d;
  logic              last_q, last_d;

  logic [X_W-1:0] cnt_x;
  logic [Y_W-1:0] cnt_y;
  logic           cnt_last;
  logic           cnt_clr;
  logic           cnt_en;

  raster_counter #(
    .X_W  (X_W),
    .Y_W  (Y_W),
    .X_MAX(X_MAX),
    .Y_MAX(Y_MAX)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .x   (cnt_x),
    .y   (cnt_y),
    .last(cnt_last)
  );

  // next state and next output beat
  always_comb begin
    state_d = state_q;
    prog_d  = 1'b0;
    pv_d    = 1'b0;
    x_d     = '0;
    y_d     = '0;
    data_d  = '0;
    fd_d    = 1'b0;
    busy_d  = 1'b0;
    rdy_d   = 1'b0;
    bg_d    = bg_q;
    last_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        rdy_d = 1'b1;
        if (cfg_valid) begin
          prog_d = 1'b1;
          y_d    = Y_W'(cfg_addr);
          data_d = cfg_data;
        end else if (start) begin
          state_d = ST_SCAN;
          bg_d    = bg_color;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          pv_d    = 1'b1;
          x_d     = cnt_x;
          y_d     = cnt_y;
          data_d  = bg_color;
          last_d  = cnt_last;
          cnt_en  = 1'b1;
        end
      end
      ST_SCAN: begin
        busy_d = 1'b1;
        pv_d   = 1'b1;
        x_d    = cnt_x;
        y_d    = cnt_y;
        data_d = bg_q;
        last_d = cnt_last;
        cnt_en = 1'b1;
        if (last_q) begin
          fd_d = 1'b1;
          if (continuous) begin
            bg_d   = bg_color;
            data_d = bg_color;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            pv_d    = 1'b0;
            x_d     = '0;
            y_d     = '0;
            data_d  = '0;
            last_d  = 1'b0;
            cnt_en  = 1'b0;
            cnt_clr = 1'b1;
            rdy_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prog_q  <= 1'b0;
      pv_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
      bg_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      pv_q    <= pv_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      bg_q    <= bg_d;
      last_q  <= last_d;
    end
  end

  assign cfg_ready   = rdy_q;
  assign program_out = prog_q;
  assign pixel_valid = pv_q;
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign data_out    = data_q;
  assign frame_done  = fd_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Self-checking bench for pixel_stream_source on a reduced
// raster so full frames fit in a short run.
module tb_pixel_stream_source;

  localparam int XW = 11;
  localparam int YW = 12;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int XM = 4;
  localparam int YM = 6;
  localparam int N  = (XM + 1) * (YM + 1);

  typedef struct packed {
    logic          prog;
    logic          pv;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] d;
    logic          fd;
    logic          busy;
    logic          rdy;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          start;
  logic          continuous;
  logic [DW-1:0] bg_color;
  logic          program_out;
  logic          pixel_valid;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [DW-1:0] data_out;
  logic          frame_done;
  logic          busy;

  int tests = 0;
  int fails = 0;

  pixel_stream_source #(
    .X_W   (XW),
    .Y_W   (YW),
    .DATA_W(DW),
    .X_MAX (XM),
    .Y_MAX (YM),
    .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .start      (start),
    .continuous (continuous),
    .bg_color   (bg_color),
    .program_out(program_out),
    .pixel_valid(pixel_valid),
    .x_out      (x_out),
    .y_out      (y_out),
    .data_out   (data_out),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t sample();
    beat_t b;
    b.prog = program_out;
    b.pv   = pixel_valid;
    b.x    = x_out;
    b.y    = y_out;
    b.d    = data_out;
    b.fd   = frame_done;
    b.busy = busy;
    b.rdy  = cfg_ready;
    return b;
  endfunction

  function automatic beat_t idle_beat();
    beat_t b;
    b = '0;
    b.rdy = 1'b1;
    return b;
  endfunction

  function automatic beat_t prog_beat(int a, logic [DW-1:0] d);
    beat_t b;
    b = idle_beat();
    b.prog = 1'b1;
    b.y = YW'(a);
    b.d = d;
    return b;
  endfunction

  // k-th pixel of a frame: y fast, x slow
  function automatic beat_t pix(int k, logic [DW-1:0] c);
    beat_t b;
    b = '0;
    b.pv = 1'b1;
    b.x = XW'(k / (YM + 1));
    b.y = YW'(k % (YM + 1));
    b.d = c;
    b.busy = 1'b1;
    return b;
  endfunction

  task automatic test_reset();
    beat_t o;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    o = sample();
    tests++;
    if (o !== idle_beat()) begin
      fails++;
      $display("FAIL reset: got %h want %h", o, idle_beat());
    end
  endtask

  task automatic test_cfg();
    int a[5];
    logic [DW-1:0] d[5];
    beat_t o, e;
    a = '{0, 1, 2, 3, 4};
    d = '{32'd540, 32'd1080, 32'd270, 32'd540, 32'hFF0000FF};
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1;
      cfg_addr = AW'(a[i]);
      cfg_data = d[i];
      step();
      o = sample();
      e = prog_beat(a[i], d[i]);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL cfg_b2b[%0d]: got %h want %h", i, o, e);
      end
    end
    cfg_valid = 1'b0;
    step();
    o = sample();
    tests++;
    if (o !== idle_beat()) begin
      fails++;
      $display("FAIL cfg_idle: got %h want %h", o, idle_beat());
    end
    for (int i = 0; i < 10; i++) begin
      cfg_valid = 1'($urandom);
      cfg_addr = AW'($urandom);
      cfg_data = $urandom;
      e = cfg_valid ? prog_beat(int'(cfg_addr), cfg_data) : idle_beat();
      step();
      o = sample();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL cfg_rand[%0d]: got %h want %h", i, o, e);
      end
    end
    cfg_valid = 1'b0;
    step();
  endtask

  task automatic test_frame();
    beat_t o, e;
    int k;
    bit done;
    logic [DW-1:0] c;
    c = 32'hFFFF0000;
    bg_color = c;
    continuous = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    done = 0;
    for (int cyc = 0; cyc < N + 10 && !done; cyc++) begin
      o = sample();
      if (o.pv || o.busy) begin
        e = pix(k, c);
        tests++;
        if (o !== e) begin
          fails++;
          $display("FAIL frame_px[%0d]: got %h want %h", k, o, e);
        end
        k++;
      end else begin
        e = idle_beat();
        e.fd = 1'b1;
        tests++;
        if (o !== e) begin
          fails++;
          $display("FAIL frame_end: got %h want %h", o, e);
        end
        done = 1;
      end
      cfg_valid = done ? 1'b0 : 1'($urandom);
      cfg_addr = AW'($urandom);
      cfg_data = $urandom;
      continuous = (k == N) ? 1'b0 : 1'($urandom);
      bg_color = $urandom;
      step();
    end
    cfg_valid = 1'b0;
    continuous = 1'b0;
    tests++;
    if (k !== N || !done) begin
      fails++;
      $display("FAIL frame_count: got %0d beats done=%0d want %0d", k, done, N);
    end
    o = sample();
    tests++;
    if (o !== idle_beat()) begin
      fails++;
      $display("FAIL frame_after: got %h want %h", o, idle_beat());
    end
  endtask

  task automatic test_start_collision();
    beat_t o, e;
    logic [DW-1:0] c;
    c = $urandom;
    cfg_valid = 1'b1;
    start = 1'b1;
    cfg_addr = 3'd3;
    cfg_data = $urandom;
    bg_color = c;
    e = prog_beat(3, cfg_data);
    step();
    o = sample();
    tests++;
    if (o !== e) begin
      fails++;
      $display("FAIL collide_prog: got %h want %h", o, e);
    end
    cfg_valid = 1'b0;
    start = 1'b0;
    step();
    o = sample();
    tests++;
    if (o !== idle_beat()) begin
      fails++;
      $display("FAIL collide_idle: got %h want %h", o, idle_beat());
    end
    start = 1'b1;
    step();
    start = 1'b0;
    bg_color = ~c;
    o = sample();
    e = pix(0, c);
    tests++;
    if (o !== e) begin
      fails++;
      $display("FAIL collide_start: got %h want %h", o, e);
    end
    step();
    o = sample();
    e = pix(1, c);
    tests++;
    if (o !== e) begin
      fails++;
      $display("FAIL collide_px1: got %h want %h", o, e);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    o = sample();
    tests++;
    if (o !== idle_beat()) begin
      fails++;
      $display("FAIL collide_rst: got %h want %h", o, idle_beat());
    end
  endtask

  task automatic test_continuous();
    beat_t o, e;
    int k, fdn;
    bit done;
    logic [DW-1:0] c1, c2;
    c1 = $urandom;
    c2 = c1 ^ 32'h00FF00FF;
    bg_color = c1;
    continuous = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    fdn = 0;
    done = 0;
    for (int cyc = 0; cyc < 2 * N + 10 && !done; cyc++) begin
      o = sample();
      if (o.pv || o.busy) begin
        e = pix(k % N, (k < N) ? c1 : c2);
        e.fd = (k == N);
        tests++;
        if (o !== e) begin
          fails++;
          $display("FAIL cont_px[%0d]: got %h want %h", k, o, e);
        end
        k++;
      end else begin
        e = idle_beat();
        e.fd = 1'b1;
        tests++;
        if (o !== e) begin
          fails++;
          $display("FAIL cont_end: got %h want %h", o, e);
        end
        done = 1;
      end
      if (o.fd) fdn++;
      cfg_valid = done ? 1'b0 : 1'($urandom);
      cfg_addr = AW'($urandom);
      cfg_data = $urandom;
      if (k == N) continuous = 1'b1;
      else if (k == 2 * N) continuous = 1'b0;
      else continuous = 1'($urandom);
      bg_color = (k == N) ? c2 : $urandom;
      step();
    end
    cfg_valid = 1'b0;
    continuous = 1'b0;
    tests++;
    if (k !== 2 * N || fdn !== 2 || !done) begin
      fails++;
      $display("FAIL cont_count: got %0d beats %0d pulses want %0d beats 2 pulses", k, fdn, 2 * N);
    end
  endtask

  task automatic test_reset_mid_scan(int stop_k);
    beat_t o, e;
    logic [DW-1:0] c;
    c = $urandom;
    bg_color = c;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < stop_k; k++) begin
      continuous = 1'($urandom);
      step();
    end
    continuous = 1'b0;
    o = sample();
    e = pix(stop_k, c);
    tests++;
    if (o !== e) begin
      fails++;
      $display("FAIL rst_pre[%0d]: got %h want %h", stop_k, o, e);
    end
    rst = 1'b1;
    step();
    o = sample();
    tests++;
    if (o !== idle_beat()) begin
      fails++;
      $display("FAIL rst_mid[%0d]: got %h want %h", stop_k, o, idle_beat());
    end
    rst = 1'b0;
    step();
    o = sample();
    tests++;
    if (o !== idle_beat()) begin
      fails++;
      $display("FAIL rst_post[%0d]: got %h want %h", stop_k, o, idle_beat());
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    start = 1'b0;
    continuous = 1'b0;
    bg_color = '0;
    test_reset();
    test_cfg();
    test_frame();
    test_start_collision();
    test_continuous();
    test_reset_mid_scan(2 * (YM + 1) + 3);
    test_reset_mid_scan(N - 1);
    test_cfg();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_stream_source.md
Name: pixel_stream_source

Overview:
Head of the render pipeline, directly upstream of the shape renderer stages. It turns host configuration writes into single-cycle programming beats (program_out=1, y_out = register index). On a start request it emits one full raster frame of background-coloured pixels, one per clock, in the order the renderers consume: y is the fast counter, x the slow one.

Parameters:
X_W, 11, width of x coordinate
Y_W, 12, width of y coordinate
DATA_W, 32, pixel/config word width (ARGB)
X_MAX, 1079, last x value of a frame
Y_MAX, 2159, last y value of a frame
ADDR_W, 3, width of config register index

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  host config write request
cfg_ready  out  1  write accepted when cfg_valid & cfg_ready at posedge
cfg_addr  in  ADDR_W  renderer register index (0=x,1=y,2=width,3=height,4=colour)
cfg_data  in  DATA_W  register value
start  in  1  request one frame scan
continuous  in  1  sampled on last pixel; 1 = wrap to next frame with no gap
bg_color  in  DATA_W  background colour, latched on scan start
program_out  out  1  to renderer program_in
pixel_valid  out  1  x_out/y_out/data_out carry a frame pixel
x_out  out  X_W  to renderer x
y_out  out  Y_W  to renderer y
data_out  out  DATA_W  to renderer data_in
frame_done  out  1  one-cycle pulse after last pixel of a frame
busy  out  1  high while in SCAN

Behaviour:
- All outputs are registered. Reset value of every output is 0, except cfg_ready, which is 1 (IDLE). Latched bg_color resets to 0.
- States: IDLE, SCAN.
- IDLE:
  - cfg_ready = 1.
  - Accepted write at edge N: in cycle N+1, program_out=1, pixel_valid=0, x_out=0, y_out=zero-extended cfg_addr, data_out=cfg_data.
  - With no write, program_out=0 next cycle.
  - Back-to-back writes produce back-to-back programming beats.
- start in IDLE:
  - Sampled only when cfg_valid=0. If cfg_valid and start are both high, the write wins and start is ignored; the host must re-assert start.
  - On start at edge N: latch bg_color, go to SCAN, cfg_ready=0.
  - Cycle N+1 presents (0,0) with pixel_valid=1, program_out=0, data_out=latched colour.
- SCAN:
  - Each cycle y_out increments.
  - At y_out==Y_MAX: y wraps to 0 and x increments.
  - Last pixel is (X_MAX,Y_MAX); a frame is (X_MAX+1)*(Y_MAX+1) = 2,332,800 beats.
  - cfg_valid is ignored in SCAN (cfg_ready=0). start is ignored in SCAN.
- End of frame, on the cycle after the last pixel is presented:
  - If continuous was 1 when the last pixel was presented: present (0,0) immediately, re-latch bg_color, pulse frame_done, stay in SCAN.
  - Otherwise: pixel_valid=0, x/y/data=0, frame_done=1 for one cycle, busy=0, state=IDLE, cfg_ready=1.
- Counter comparison uses equality against X_MAX/Y_MAX. No counter value above a MAX is ever presented.
- rst asserted at any edge, including mid-scan or mid-programming: next cycle all outputs take reset values and state=IDLE. No partial frame_done is produced.
- Counters never overflow their field widths; X_MAX < 2^X_W and Y_MAX < 2^Y_W are required at elaboration.

Decomposition:
- Shared package render_pkg:
  - default widths X_W/Y_W/DATA_W.
  - X_MAX/Y_MAX.
  - register index constants REG_X=0, REG_Y=1, REG_W=2, REG_H=3, REG_COLOR=4.
  - state encoding.
  - colour constants BLUE=32'hFF0000FF, RED=32'hFFFF0000.
- One sub-module, raster_counter. It holds the x/y pair with clear, enable, and last-pixel flag, so it is reusable by the output frame writer.

Test Plan:
- Reset then cfg writes (0,540),(1,1080),(2,270),(3,540),(4,FF0000FF) back-to-back -> five consecutive program_out=1 beats, y_out=0..4, data_out matching, x_out=0.
- start with bg_color=FFFF0000, continuous=0 -> first beat (0,0) one cycle after start. Then (0,1) and (0,2159)->(1,0) transitions. Last beat (1079,2159), then frame_done pulse. Exactly 2,332,800 pixel_valid beats, all data FFFF0000.
- start and cfg_valid both high in IDLE -> only program beat issued, busy stays 0. A later start alone begins the scan.
- continuous=1 at last pixel -> (1079,2159) followed immediately by (0,0), frame_done pulses once, new bg_color latched.
- rst asserted at pixel (500,1000) -> next cycle all outputs 0, cfg_ready=1, no frame_done.
- cfg_valid during SCAN -> cfg_ready=0, no program_out beat, scan sequence unbroken.
